i2c_target_rx: RTL and testbench



---
 rtl/i2c_target_rx.sv | 174 +++++++++++++++++
 tb/tb_i2c_target_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: synchronizes SCL/SDA, tracks START/STOP, ACKs a matching write
// address and hands each ACKed data byte to local logic through a one-deep valid/ready register.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h54,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       addressed,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_rx_valid, r_busy, r_addressed, r_overrun;
    logic [7:0] r_rx_data;
    logic       w_load, w_ovr, w_addr_set;

    // Synchronizers reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl &  r_scl_d;
    assign w_start    =  w_scl & ~w_sda &  r_sda_d;
    assign w_stop     =  w_scl &  w_sda & ~r_sda_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_sda_oe <= w_sda_oe_nxt;
        end
    end

    // In the ACK states r_sda_oe tells the first SCL fall (drive) from the second (release).
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_sda_oe_nxt = r_sda_oe;
        w_load       = 1'b0;
        w_ovr        = 1'b0;
        w_addr_set   = 1'b0;
        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 3'd0;
        end else begin
            case (r_state)
                S_ADDR, S_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = {r_shift[6:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_state == S_DATA)
                                w_state_nxt = S_DATA_ACK;
                            else if ({r_shift[6:0], w_sda} == {TARGET_ADDR, 1'b0})
                                w_state_nxt = S_ADDR_ACK;
                            else
                                w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                            w_addr_set   = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_DATA;
                        end
                    end
                end
                S_DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (r_sda_oe) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_DATA;
                        end else if (!r_rx_valid) begin
                            w_sda_oe_nxt = 1'b1;
                            w_load       = 1'b1;
                        end else begin
                            // Holding register full (even if being drained this cycle): NACK.
                            w_ovr       = 1'b1;
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_stop) begin
                r_busy      <= 1'b0;
                r_addressed <= 1'b0;
            end else if (w_start) begin
                r_busy      <= 1'b1;
                r_addressed <= 1'b0;
            end else if (w_addr_set) begin
                r_addressed <= 1'b1;
            end
        end
    end

    // Holding register is decoupled from the bus FSM; a pending byte survives STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else if (w_load) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_shift;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign sda_oe    = r_sda_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign addressed = r_addressed;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged I2C controller drives an open-drain bus model.
module tb_i2c_target_rx;
    localparam int H = 8;

    logic       clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, rx_ready = 1'b1;
    logic       scl_in, sda_in, sda_oe, rx_valid, busy, addressed, overrun;
    logic [7:0] rx_data;

    int         n_vec = 0, n_err = 0, ovr_cnt = 0;
    bit         oe_seen = 0, busy_seen = 0;
    logic [7:0] got[$];
    logic       a;

    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    i2c_target_rx #(.TARGET_ADDR(7'h54), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
        .addressed(addressed), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (overrun) ovr_cnt++;
        if (sda_oe) oe_seen = 1;
        if (busy) busy_seen = 1;
    end

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H);
        m_sda = 1'b0; wt(H);
        m_scl = 1'b0; wt(H);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wt(H);
        m_scl = 1'b1; wt(H);
        m_sda = 1'b1; wt(H);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wt(H);
            m_scl = 1'b1; wt(H);
            m_scl = 1'b0; wt(H);
        end
    endtask

    // Returns the bus level in the middle of the ACK clock: 0 = ACK.
    task automatic ack_slot(output logic ack);
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H/2);
        ack = sda_in; wt(H/2);
        m_scl = 1'b0; wt(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_slot(ack);
    endtask

    initial begin
        wt(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0; wt(4);

        // Address + data accept
        i2c_start();
        chk("t1_busy", busy, 1);
        send_byte(8'hA8, a); chk("t1_addr_ack", a, 0);
        chk("t1_addressed", addressed, 1);
        send_byte(8'h4D, a); chk("t1_data_ack", a, 0);
        i2c_stop();
        chk("t1_busy_low", busy, 0);
        chk("t1_addr_low", addressed, 0);
        chk("t1_count", got.size(), 1);
        if (got.size() > 0) chk("t1_byte", got[0], 8'h4D);

        // Read request to our address: ignored
        oe_seen = 0; got.delete();
        i2c_start();
        send_byte(8'hA9, a); chk("t2_nack", a, 1);
        chk("t2_state_ignore", 32'(dut.r_state), 32'd5);
        send_byte(8'h12, a); chk("t2_data_nack", a, 1);
        chk("t2_oe_never", oe_seen, 0);
        chk("t2_rx_valid", rx_valid, 0);
        i2c_stop();
        chk("t2_state_idle", 32'(dut.r_state), 32'd0);

        // Overrun
        rx_ready = 1'b0; ovr_cnt = 0;
        i2c_start();
        send_byte(8'hA8, a); chk("t3_addr_ack", a, 0);
        send_byte(8'h11, a); chk("t3_d1_ack", a, 0);
        chk("t3_valid", rx_valid, 1);
        chk("t3_data", rx_data, 8'h11);
        send_byte(8'h22, a); chk("t3_d2_nack", a, 1);
        chk("t3_ovr_cnt", ovr_cnt, 1);
        chk("t3_data_kept", rx_data, 8'h11);
        i2c_stop();
        chk("t3_valid_after_stop", rx_valid, 1);
        rx_ready = 1'b1; wt(3);
        chk("t3_drained", rx_valid, 0);
        chk("t3_count", got.size(), 1);
        if (got.size() > 0) chk("t3_byte", got[0], 8'h11);

        // Repeated START
        got.delete();
        i2c_start();
        send_byte(8'hA8, a); chk("t4_a1_ack", a, 0);
        send_byte(8'h33, a); chk("t4_d1_ack", a, 0);
        chk("t4_addressed1", addressed, 1);
        i2c_start();
        chk("t4_addr_dropped", addressed, 0);
        send_byte(8'hA8, a); chk("t4_a2_ack", a, 0);
        chk("t4_addressed2", addressed, 1);
        send_byte(8'h44, a); chk("t4_d2_ack", a, 0);
        i2c_stop();
        chk("t4_count", got.size(), 2);
        if (got.size() > 1) begin
            chk("t4_byte0", got[0], 8'h33);
            chk("t4_byte1", got[1], 8'h44);
        end

        // Reset during the address ACK
        rx_ready = 1'b0;
        i2c_start();
        send_bits(8'hA8);
        chk("t5_oe_before_rst", sda_oe, 1);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("t5_oe_async", sda_oe, 0);
        wt(2); rst = 1'b0;
        ack_slot(a); chk("t5_ack_slot_released", a, 1);
        send_byte(8'h55, a); chk("t5_data_nack", a, 1);
        chk("t5_no_valid", rx_valid, 0);
        i2c_stop();
        rx_ready = 1'b1; got.delete();
        i2c_start();
        send_byte(8'hA8, a); chk("t5_readdr_ack", a, 0);
        send_byte(8'h66, a); chk("t5_redata_ack", a, 0);
        i2c_stop();
        chk("t5_count", got.size(), 1);
        if (got.size() > 0) chk("t5_byte", got[0], 8'h66);

        // SDA toggling with SCL low: no START, no drive
        wt(4); busy_seen = 0; oe_seen = 0;
        m_scl = 1'b0; wt(H);
        for (int i = 0; i < 6; i++) begin
            m_sda = ~m_sda; wt(3 + i);
        end
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H);
        chk("t6_busy_never", busy_seen, 0);
        chk("t6_oe_never", oe_seen, 0);
        chk("t6_state_idle", 32'(dut.r_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
